// File: rtl/bus_slave_interface_if.sv
// Bus-side handshake bundle between a CPU-side bus initiator and the
// bus_slave_interface responder.
//   bus_stb_i  : master strobe, held high until ack
//   bus_we_i   : 1 = write, 0 = read
//   bus_adr_i  : byte address
//   bus_dat_i  : write data (master to slave)
//   bus_dat_o  : read data (slave to master)
//   bus_ack_o  : one-cycle transfer-complete pulse
// Signal names keep the slave's point of view (_i into the slave, _o out).
interface bus_slave_interface_if;
   logic        bus_stb_i;
   logic        bus_we_i;
   logic [31:0] bus_adr_i;
   logic [31:0] bus_dat_i;
   logic [31:0] bus_dat_o;
   logic        bus_ack_o;

   modport master (
      output bus_stb_i, bus_we_i, bus_adr_i, bus_dat_i,
      input  bus_dat_o, bus_ack_o
   );

   modport slave (
      input  bus_stb_i, bus_we_i, bus_adr_i, bus_dat_i,
      output bus_dat_o, bus_ack_o
   );
endinterface

// File: rtl/bus_slave_interface.sv
// Bus slave responder: decodes an address window, latches one transfer,
// hands it to a device through a req/rdy handshake and returns a single
// ack pulse. A device that never answers is cut off after TIMEOUT request
// cycles; that ack carries 32'hDEAD_BEEF on reads and sets a sticky error.
//
// Ports
//   bus_clk_i  : clock, all logic on the rising edge
//   bus_rst_i  : synchronous active-high reset
//   bus        : bus_slave_interface_if.slave (stb/we/adr/dat in, ack/dat out)
//   dev_req_o  : device request, high for the whole REQ phase
//   dev_we_o   : latched write enable
//   dev_adr_o  : latched offset within the decoded window
//   dev_dat_o  : latched write data
//   dev_dat_i  : device read data, valid with dev_rdy_i
//   dev_rdy_i  : device completion
//   err_o      : sticky timeout flag, cleared only by reset
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for a selected strobe
// REQ   | transfer latched, dev_req_o high, waiting for rdy or timeout
// ACK   | bus_ack_o high for this one cycle, then back to IDLE
module bus_slave_interface #(
   parameter logic [31:0] BASE_ADR = 32'h0000_1000,
   parameter logic [31:0] ADR_MASK = 32'hFFFF_F000,
   parameter logic [7:0]  TIMEOUT  = 8'd16
) (
   input  logic                   bus_clk_i,
   input  logic                   bus_rst_i,
   bus_slave_interface_if.slave   bus,
   output logic                   dev_req_o,
   output logic                   dev_we_o,
   output logic [31:0]            dev_adr_o,
   output logic [31:0]            dev_dat_o,
   input  logic [31:0]            dev_dat_i,
   input  logic                   dev_rdy_i,
   output logic                   err_o
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_ACK  = 2'd2
   } state_t;

   localparam logic [7:0]  TO_LAST  = TIMEOUT - 8'd1;
   localparam logic [31:0] DEAD_VAL = 32'hDEAD_BEEF;

   state_t      state_q, state_d;
   logic        ack_q, ack_d;
   logic        req_q, req_d;
   logic        we_q, we_d;
   logic [31:0] adr_q, adr_d;
   logic [31:0] wdat_q, wdat_d;
   logic [31:0] rdat_q, rdat_d;
   logic        err_q, err_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        sel;

   assign sel = (bus.bus_adr_i & ADR_MASK) == BASE_ADR;

   always_comb begin
      state_d = state_q;
      ack_d   = 1'b0;
      req_d   = req_q;
      we_d    = we_q;
      adr_d   = adr_q;
      wdat_d  = wdat_q;
      rdat_d  = rdat_q;
      err_d   = err_q;
      cnt_d   = cnt_q;

      case (state_q)
         ST_IDLE: begin
            req_d = 1'b0;
            if (bus.bus_stb_i && sel) begin
               we_d    = bus.bus_we_i;
               adr_d   = bus.bus_adr_i & ~ADR_MASK;
               wdat_d  = bus.bus_dat_i;
               cnt_d   = 8'd0;
               req_d   = 1'b1;
               state_d = ST_REQ;
            end
         end

         ST_REQ: begin
            // rdy is tested first so a completion in the timeout cycle is
            // treated as a normal transfer.
            if (dev_rdy_i) begin
               if (!we_q) begin
                  rdat_d = dev_dat_i;
               end
               req_d   = 1'b0;
               ack_d   = 1'b1;
               state_d = ST_ACK;
            end else if (cnt_q == TO_LAST) begin
               if (!we_q) begin
                  rdat_d = DEAD_VAL;
               end
               err_d   = 1'b1;
               req_d   = 1'b0;
               ack_d   = 1'b1;
               state_d = ST_ACK;
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end

         ST_ACK: begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
         end

         default: begin
            req_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge bus_clk_i) begin
      if (bus_rst_i) begin
         state_q <= ST_IDLE;
         ack_q   <= 1'b0;
         req_q   <= 1'b0;
         we_q    <= 1'b0;
         adr_q   <= 32'd0;
         wdat_q  <= 32'd0;
         rdat_q  <= 32'd0;
         err_q   <= 1'b0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         ack_q   <= ack_d;
         req_q   <= req_d;
         we_q    <= we_d;
         adr_q   <= adr_d;
         wdat_q  <= wdat_d;
         rdat_q  <= rdat_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.bus_ack_o = ack_q;
   assign bus.bus_dat_o = rdat_q;
   assign dev_req_o     = req_q;
   assign dev_we_o      = we_q;
   assign dev_adr_o     = adr_q;
   assign dev_dat_o     = wdat_q;
   assign err_o         = err_q;

endmodule
